player_ctl: RTL and testbench
=============================

// Module: player_ctl
// PURPOSE
//  Per-player motion controller upstream of the game-state FSM: turns move/jump requests into a registered
//  12-bit on-screen position (xpos_player, ypos_player). The x position is what the state FSM
//  compares against its finish column. Motion is active only in LEVEL_1, and it is updated on an
//  internal motion tick so that speed does not depend on clk_40. Two instances are used, one per player.
// PARAMETERS
//  TICK_DIV  400_000  clk_40 cycles per motion tick (100 Hz at 40 MHz)
//  X_START   20       x after reset and while game_state==START
//  X_MIN     0        left saturation limit
//  X_MAX     780      right saturation limit
//  Y_FLOOR   500      ground y, which is also the start y (screen y grows downward)
//  Y_MIN     40       ceiling; ypos never goes below it
//  STEP      2        horizontal pixels per tick
//  JUMP_V0   12       initial upward speed, px/tick
//  VY_MAX    12       terminal falling speed, px/tick
// PORTS
//  clk_40       in   1   system clock, 40 MHz
//  rst          in   1   asynchronous, active-low reset (0 = reset)
//  game_state   in   g_state  state from state_pkg (START/LEVEL_1/FINISH)
//  move_left    in   1   level, hold to move left
//  move_right   in   1   level, hold to move right
//  jump         in   1   level; a rising edge requests a jump
//  xpos_player  out  12  registered x position
//  ypos_player  out  12  registered y position
//  in_air       out  1   1 while in the RISING or FALLING state
// BEHAVIOUR
//  Reset (rst=0, async): xpos=X_START, ypos=Y_FLOOR, in_air=0, vy=0, tick counter=0,
//   jump_pend=0, jump_d=0, FSM=IDLE.
//  Tick: the counter runs 0..TICK_DIV-1 only while game_state==LEVEL_1. tick=1 for the single cycle with
//   cnt==TICK_DIV-1, and the counter wraps to 0. In any other game_state the counter is held at 0.
//  Jump edge: jump_d<=jump every cycle. If jump & ~jump_d, then jump_pend<=1. jump_pend clears on the tick
//   that consumes it and also whenever game_state!=LEVEL_1. Holding jump does not re-trigger.
//  Outputs are registered and update on the clk_40 edge at which tick==1 (latency 1 cycle from tick).
//  Horizontal, on tick: move_left&~move_right -> x=max(x-STEP,X_MIN);
//   move_right&~move_left -> x=min(x+STEP,X_MAX); both or neither -> x unchanged.
//   Compute in 13 bits so no wrap-around occurs; x-STEP<X_MIN clamps to X_MIN.
//  Vertical FSM (vy is unsigned 8-bit magnitude), evaluated on tick only:
//   IDLE    : if game_state==LEVEL_1 -> GROUND (no motion on this tick)
//   GROUND  : jump_pend -> RISING with vy=JUMP_V0, jump_pend=0; else stay, ypos=Y_FLOOR
//   RISING  : if ypos-vy<=Y_MIN: ypos=Y_MIN, vy=0, go FALLING; else ypos-=vy, vy-=1;
//             when the new vy==0 -> FALLING
//   FALLING : vy=min(vy+1,VY_MAX); if ypos+vy_new>=Y_FLOOR: ypos=Y_FLOOR, vy=0, go GROUND;
//             else ypos+=vy_new
//   A jump edge seen while RISING/FALLING sets jump_pend, which is taken on the first GROUND tick.
//  game_state handling (checked every cycle, overriding the tick logic):
//   START   -> synchronous re-init: x=X_START, y=Y_FLOOR, vy=0, FSM=IDLE, in_air=0
//   FINISH  -> freeze: all position/velocity/FSM registers hold; in_air holds
//   LEVEL_1 -> normal operation. An undefined state is treated as START.
//  A simultaneous tick and jump edge on the same cycle: the edge is not seen by that tick; it is used on the next tick.
//  Reset asserted mid-jump returns to the reset values immediately (async); nothing resumes after release.
// TESTING
//  1 Release reset, game_state=START, 1000 cycles -> x=20, y=500, in_air=0, counter stays 0.
//  2 LEVEL_1 with move_right held for 5 ticks (TICK_DIV=4 in sim) -> x=30; with both pressed for 3 ticks -> x stays 30.
//  3 move_left held from x=20 for 20 ticks -> x decreases by 2 per tick and saturates at 0, never wraps to 4094.
//  4 One jump pulse on GROUND -> y sequence 488,477,467,... up to the apex, then a fall back to y=500 exactly;
//    in_air=1 throughout, GROUND after landing; holding jump high for the whole time gives a single jump.
//  5 Y_MIN=480, jump -> y clamps to 480, FALLING starts with vy=0, then landing at 500.
//  6 Mid-jump, switch game_state to FINISH -> x/y frozen; back to START -> x=20, y=500 next cycle;
//    then assert rst low mid-jump in LEVEL_1 -> outputs reset without waiting for a clock edge.

Source files
------------

// File: rtl/player_ctl.sv
// player_ctl: per-player motion controller. Converts move/jump requests into a
// registered 12-bit screen position that advances once per motion tick, so the
// speed of the sprite does not depend on the system clock frequency.
// The game_state encoding matches the state FSM: 0=START, 1=LEVEL_1, 2=FINISH;
// the unused code 3 behaves like START.
module player_ctl #(
    parameter int TICK_DIV = 400_000,
    parameter int X_START  = 20,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 780,
    parameter int Y_FLOOR  = 500,
    parameter int Y_MIN    = 40,
    parameter int STEP     = 2,
    parameter int JUMP_V0  = 12,
    parameter int VY_MAX   = 12
) (
    input  logic        clk_40,
    input  logic        rst,
    input  logic [1:0]  game_state,
    input  logic        move_left,
    input  logic        move_right,
    input  logic        jump,
    output logic [11:0] xpos_player,
    output logic [11:0] ypos_player,
    output logic        in_air
);

    localparam logic [1:0] GS_LEVEL_1 = 2'd1;
    localparam logic [1:0] GS_FINISH  = 2'd2;

    localparam int              CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    // Positions are handled in 13 bits so that x-STEP or y+vy never wraps.
    localparam logic [12:0] X_START_W = 13'(X_START);
    localparam logic [12:0] X_MIN_W   = 13'(X_MIN);
    localparam logic [12:0] X_MAX_W   = 13'(X_MAX);
    localparam logic [12:0] Y_FLOOR_W = 13'(Y_FLOOR);
    localparam logic [12:0] Y_MIN_W   = 13'(Y_MIN);
    localparam logic [12:0] STEP_W    = 13'(STEP);
    localparam logic [7:0]  JUMP_V0_W = 8'(JUMP_V0);
    localparam logic [7:0]  VY_MAX_W  = 8'(VY_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GROUND  = 2'd1,
        RISING  = 2'd2,
        FALLING = 2'd3
    } vstate_t;

    vstate_t          state;
    vstate_t          state_nx;
    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic             in_level;
    logic             in_finish;
    logic             jump_d;
    logic             jump_edge;
    logic             jump_pend;
    logic             pend_nx;
    logic [11:0]      x_nx;
    logic [11:0]      y_nx;
    logic [7:0]       vy;
    logic [7:0]       vy_nx;
    logic [7:0]       vy_up;
    logic [7:0]       vy_dn;
    logic [12:0]      x_w;
    logic [12:0]      y_w;
    logic [12:0]      vy_w;
    logic [12:0]      vy_up_w;

    assign in_level  = (game_state == GS_LEVEL_1);
    assign in_finish = (game_state == GS_FINISH);
    assign tick      = in_level && (cnt == CNT_LAST);
    assign jump_edge = jump && !jump_d;

    assign x_w     = {1'b0, xpos_player};
    assign y_w     = {1'b0, ypos_player};
    assign vy_w    = {5'b0, vy};
    assign vy_up   = (vy >= VY_MAX_W) ? VY_MAX_W : vy + 8'd1;
    assign vy_up_w = {5'b0, vy_up};
    assign vy_dn   = (vy == 8'd0) ? 8'd0 : vy - 8'd1;

    assign in_air  = (state == RISING) || (state == FALLING);

    // Motion tick divider: free-runs only during LEVEL_1, parked at 0 otherwise.
    always_ff @(posedge clk_40 or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!in_level || (cnt == CNT_LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Delayed copy of jump for rising-edge detection.
    always_ff @(posedge clk_40 or negedge rst) begin
        if (!rst) begin
            jump_d <= 1'b0;
        end else begin
            jump_d <= jump;
        end
    end

    // Position, velocity, pending-jump and vertical FSM state registers.
    always_ff @(posedge clk_40 or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            xpos_player <= X_START_W[11:0];
            ypos_player <= Y_FLOOR_W[11:0];
            vy          <= 8'd0;
            jump_pend   <= 1'b0;
        end else begin
            state       <= state_nx;
            xpos_player <= x_nx;
            ypos_player <= y_nx;
            vy          <= vy_nx;
            jump_pend   <= pend_nx;
        end
    end

    // Next-state logic: game_state override first, then per-tick motion.
    always_comb begin
        state_nx = state;
        x_nx     = xpos_player;
        y_nx     = ypos_player;
        vy_nx    = vy;
        pend_nx  = jump_pend;

        if (!in_level && !in_finish) begin
            // START (or an undefined code): re-initialise every cycle.
            state_nx = IDLE;
            x_nx     = X_START_W[11:0];
            y_nx     = Y_FLOOR_W[11:0];
            vy_nx    = 8'd0;
            pend_nx  = 1'b0;
        end else if (in_finish) begin
            // FINISH: motion frozen, stale jump requests discarded.
            pend_nx = 1'b0;
        end else begin
            if (tick) begin
                // Horizontal: opposing or absent requests cancel out.
                if (move_left && !move_right) begin
                    if (x_w < X_MIN_W + STEP_W) begin
                        x_nx = X_MIN_W[11:0];
                    end else begin
                        x_nx = 12'(x_w - STEP_W);
                    end
                end else if (move_right && !move_left) begin
                    if (x_w + STEP_W > X_MAX_W) begin
                        x_nx = X_MAX_W[11:0];
                    end else begin
                        x_nx = 12'(x_w + STEP_W);
                    end
                end

                // Vertical: screen y grows downward, so rising subtracts.
                case (state)
                    IDLE: begin
                        state_nx = GROUND;
                    end
                    GROUND: begin
                        if (jump_pend) begin
                            state_nx = RISING;
                            vy_nx    = JUMP_V0_W;
                            pend_nx  = 1'b0;
                        end else begin
                            y_nx = Y_FLOOR_W[11:0];
                        end
                    end
                    RISING: begin
                        if (y_w <= Y_MIN_W + vy_w) begin
                            y_nx     = Y_MIN_W[11:0];
                            vy_nx    = 8'd0;
                            state_nx = FALLING;
                        end else begin
                            y_nx  = 12'(y_w - vy_w);
                            vy_nx = vy_dn;
                            if (vy_dn == 8'd0) begin
                                state_nx = FALLING;
                            end
                        end
                    end
                    FALLING: begin
                        if (y_w + vy_up_w >= Y_FLOOR_W) begin
                            y_nx     = Y_FLOOR_W[11:0];
                            vy_nx    = 8'd0;
                            state_nx = GROUND;
                        end else begin
                            y_nx  = 12'(y_w + vy_up_w);
                            vy_nx = vy_up;
                        end
                    end
                    default: begin
                        state_nx = IDLE;
                    end
                endcase
            end

            // An edge arriving on a tick cycle is kept for the following tick.
            if (jump_edge) begin
                pend_nx = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_player_ctl.sv
// tb_player_ctl: directed bench for player_ctl with a 4-cycle motion tick.
// A second instance with a high ceiling (Y_MIN=480) shares the stimulus.
module tb_player_ctl;

    localparam logic [1:0] GS_START   = 2'd0;
    localparam logic [1:0] GS_LEVEL_1 = 2'd1;
    localparam logic [1:0] GS_FINISH  = 2'd2;
    localparam logic [1:0] GS_UNDEF   = 2'd3;

    logic        clk_40 = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  game_state = GS_START;
    logic        move_left = 1'b0;
    logic        move_right = 1'b0;
    logic        jump = 1'b0;
    logic [11:0] xpos_player;
    logic [11:0] ypos_player;
    logic        in_air;
    logic [11:0] xpos_low;
    logic [11:0] ypos_low;
    logic        in_air_low;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_40 = ~clk_40;

    player_ctl #(.TICK_DIV(4)) dut (
        .clk_40      (clk_40),
        .rst         (rst),
        .game_state  (game_state),
        .move_left   (move_left),
        .move_right  (move_right),
        .jump        (jump),
        .xpos_player (xpos_player),
        .ypos_player (ypos_player),
        .in_air      (in_air)
    );

    player_ctl #(.TICK_DIV(4), .Y_MIN(480)) dut_low (
        .clk_40      (clk_40),
        .rst         (rst),
        .game_state  (game_state),
        .move_left   (move_left),
        .move_right  (move_right),
        .jump        (jump),
        .xpos_player (xpos_low),
        .ypos_player (ypos_low),
        .in_air      (in_air_low)
    );

    typedef struct {
        string      name;
        logic [1:0] gs;
        logic       ml;
        logic       mr;
        int         n_ticks;
        int         ex;
        int         ey;
        int         eair;
    } vec_t;

    vec_t tbl[7];

    // Expected y / in_air per tick for one jump from the floor.
    int ey_main[25] = '{500, 488, 477, 467, 458, 450, 443, 437, 432, 428, 425, 423, 422,
                        423, 425, 428, 432, 437, 443, 450, 458, 467, 477, 488, 500};
    int ey_low[25]  = '{500, 488, 480, 481, 483, 486, 490, 495, 500, 500, 500, 500, 500,
                        500, 500, 500, 500, 500, 500, 500, 500, 500, 500, 500, 500};

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_40);
    endtask

    task automatic ticks(input int n);
        cycles(4 * n);
    endtask

    initial begin
        tbl[0] = '{"right5",      GS_LEVEL_1, 1'b0, 1'b1, 5,   30,  500, 0};
        tbl[1] = '{"both3",       GS_LEVEL_1, 1'b1, 1'b1, 3,   30,  500, 0};
        tbl[2] = '{"none2",       GS_LEVEL_1, 1'b0, 1'b0, 2,   30,  500, 0};
        tbl[3] = '{"left5",       GS_LEVEL_1, 1'b1, 1'b0, 5,   20,  500, 0};
        tbl[4] = '{"right_sat",   GS_LEVEL_1, 1'b0, 1'b1, 400, 780, 500, 0};
        tbl[5] = '{"finish_hold", GS_FINISH,  1'b0, 1'b1, 3,   780, 500, 0};
        tbl[6] = '{"undef_start", GS_UNDEF,   1'b0, 1'b0, 1,   20,  500, 0};

        // Reset values while rst is held low.
        cycles(1);
        check("rst_x", xpos_player, 20);
        check("rst_y", ypos_player, 500);
        check("rst_air", in_air, 0);
        rst = 1'b1;

        // START for 1000 cycles: nothing moves, divider parked.
        cycles(1000);
        check("start_x", xpos_player, 20);
        check("start_y", ypos_player, 500);
        check("start_air", in_air, 0);
        check("start_cnt", dut.cnt, 0);

        // Table of horizontal / game_state vectors.
        for (int i = 0; i < 7; i++) begin
            game_state = tbl[i].gs;
            move_left  = tbl[i].ml;
            move_right = tbl[i].mr;
            ticks(tbl[i].n_ticks);
            check({tbl[i].name, "_x"}, xpos_player, tbl[i].ex);
            check({tbl[i].name, "_y"}, ypos_player, tbl[i].ey);
            check({tbl[i].name, "_air"}, in_air, tbl[i].eair);
        end

        // Left saturation from x=20: 2 px per tick down to 0, never wrapping.
        game_state = GS_LEVEL_1;
        move_left  = 1'b1;
        move_right = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            ticks(1);
            check($sformatf("left_sat_%0d", k), xpos_player, (20 - 2 * k > 0) ? 20 - 2 * k : 0);
        end

        // Single jump with jump held high throughout; both ceilings.
        move_left = 1'b0;
        jump      = 1'b1;
        for (int k = 0; k < 25; k++) begin
            ticks(1);
            check($sformatf("jump_y_%0d", k), ypos_player, ey_main[k]);
            check($sformatf("jump_air_%0d", k), in_air, (k < 24) ? 1 : 0);
            check($sformatf("low_y_%0d", k), ypos_low, ey_low[k]);
            check($sformatf("low_air_%0d", k), in_air_low, (k < 8) ? 1 : 0);
        end
        ticks(5);
        check("held_jump_y", ypos_player, 500);
        check("held_jump_air", in_air, 0);

        // New edge: jump starts on the tick, then three rising ticks.
        jump = 1'b0;
        cycles(1);
        jump = 1'b1;
        cycles(3);
        check("rejump_y0", ypos_player, 500);
        check("rejump_air0", in_air, 1);
        ticks(3);
        check("rejump_y3", ypos_player, 467);

        // FINISH mid-jump freezes everything, even with move_right held.
        game_state = GS_FINISH;
        move_right = 1'b1;
        cycles(8);
        check("freeze_x", xpos_player, 0);
        check("freeze_y", ypos_player, 467);
        check("freeze_air", in_air, 1);

        // START re-initialises on the next clock edge.
        game_state = GS_START;
        move_right = 1'b0;
        jump       = 1'b0;
        cycles(1);
        check("restart_x", xpos_player, 20);
        check("restart_y", ypos_player, 500);
        check("restart_air", in_air, 0);

        // Jump in LEVEL_1: IDLE->GROUND, take jump, 488, 477.
        game_state = GS_LEVEL_1;
        jump       = 1'b1;
        ticks(4);
        check("jump2_y", ypos_player, 477);
        check("jump2_air", in_air, 1);

        // Asynchronous reset mid-jump, away from any clock edge.
        #2;
        rst = 1'b0;
        #1;
        check("async_x", xpos_player, 20);
        check("async_y", ypos_player, 500);
        check("async_air", in_air, 0);
        check("async_cnt", dut.cnt, 0);
        jump = 1'b0;
        cycles(3);
        rst = 1'b1;
        ticks(3);
        check("after_rst_y", ypos_player, 500);
        check("after_rst_air", in_air, 0);
        check("after_rst_x", xpos_player, 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
